// File: rtl/stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central stall controller.
// The pipeline side is the master; the controller is the slave.
interface stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             ex_mc_start;
    logic             ex_mc_done;
    logic [5:0]       stall;
    logic             mc_busy;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output stallreq_id, stallreq_ex, ex_mc_start, ex_mc_done,
        input  stall, mc_busy, mc_timeout, stall_cnt
    );

    modport slave (
        input  stallreq_id, stallreq_ex, ex_mc_start, ex_mc_done,
        output stall, mc_busy, mc_timeout, stall_cnt
    );
endinterface

// File: rtl/stall_ctrl.sv
// Central pipeline stall controller: merges ID/EX stall requests into the 6-bit
// stall bus, sequences multi-cycle EX ops with a watchdog, and counts stall cycles.
module stall_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    stall_ctrl_if.slave ctrl
);
    localparam int         TIMER_W    = $clog2(MC_TIMEOUT + 1);
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic {
        IDLE,
        MC_BUSY
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_mc_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_launch;
    logic               w_timeout_hit;
    logic               w_ex_stall;
    logic               w_mc_busy;
    logic [5:0]         w_stall;

    // A start with done in the same cycle is a single-cycle op and never stalls.
    assign w_launch      = (r_state == IDLE) && ctrl.ex_mc_start && !ctrl.ex_mc_done;
    assign w_timeout_hit = (r_state == MC_BUSY) && (r_timer == TIMER_W'(MC_TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_next_state = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (ctrl.ex_mc_done || w_timeout_hit) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Stall is released in the very cycle done or the watchdog is seen.
    always_comb begin
        w_ex_stall = 1'b0;
        w_mc_busy  = 1'b0;
        w_stall    = STALL_NONE;
        if (!rst) begin
            w_mc_busy  = (r_state == MC_BUSY);
            w_ex_stall = ctrl.stallreq_ex || w_launch
                       || ((r_state == MC_BUSY) && !ctrl.ex_mc_done && !w_timeout_hit);
            if (w_ex_stall) begin
                w_stall = STALL_EX;
            end else if (ctrl.stallreq_id) begin
                w_stall = STALL_ID;
            end
        end
    end

    // Timer counts cycles spent in MC_BUSY and is zero whenever the FSM is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_next_state != MC_BUSY) begin
            r_timer <= '0;
        end else if (r_state == IDLE) begin
            r_timer <= TIMER_W'(1);
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mc_timeout <= 1'b0;
        end else if (w_timeout_hit && !ctrl.ex_mc_done) begin
            r_mc_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall[0] && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign ctrl.stall      = w_stall;
    assign ctrl.mc_busy    = w_mc_busy;
    assign ctrl.mc_timeout = r_mc_timeout;
    assign ctrl.stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: table-driven vectors feeding a scoreboard
// queue, plus hand-written watchdog and asynchronous-reset sequences.
module tb_stall_ctrl;
    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct {
        logic       id;
        logic       ex;
        logic       start;
        logic       done;
        logic [5:0] exp_stall;
        logic       exp_busy;
        logic       exp_tmo;
    } vec_t;

    typedef struct {
        string            name;
        logic [5:0]       stall;
        logic             busy;
        logic             tmo;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    vec_t             vecs[$];
    exp_t             sb_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    stall_ctrl #(
        .MC_TIMEOUT (MC_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic id, input logic ex, input logic st, input logic dn,
                       input logic [5:0] es, input logic eb, input logic et);
        vec_t v;
        v.id = id; v.ex = ex; v.start = st; v.done = dn;
        v.exp_stall = es; v.exp_busy = eb; v.exp_tmo = et;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs just after the edge and queue what the DUT must show.
    task automatic step(input string name, input logic id, input logic ex, input logic st,
                        input logic dn, input logic [5:0] es, input logic eb, input logic et);
        exp_t e;
        @(posedge clk);
        #1;
        bus.stallreq_id = id;
        bus.stallreq_ex = ex;
        bus.ex_mc_start = st;
        bus.ex_mc_done  = dn;
        e.name  = name;
        e.stall = es;
        e.busy  = eb;
        e.tmo   = et;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
        if (es[0] && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({e.name, ".stall"}, 32'(bus.stall), 32'(e.stall));
            check({e.name, ".busy"}, 32'(bus.mc_busy), 32'(e.busy));
            check({e.name, ".tmo"}, 32'(bus.mc_timeout), 32'(e.tmo));
            check({e.name, ".cnt"}, 32'(bus.stall_cnt), 32'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state with hostile inputs: everything must read as idle.
        bus.stallreq_id = 1'b1;
        bus.stallreq_ex = 1'b1;
        bus.ex_mc_start = 1'b1;
        bus.ex_mc_done  = 1'b0;
        #2;
        check("rst.stall", 32'(bus.stall), 32'h0);
        check("rst.busy", 32'(bus.mc_busy), 32'h0);
        check("rst.tmo", 32'(bus.mc_timeout), 32'h0);
        check("rst.cnt", 32'(bus.stall_cnt), 32'h0);
        bus.stallreq_id = 1'b0;
        bus.stallreq_ex = 1'b0;
        bus.ex_mc_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 6'b000000, 0, 0);
        add(1, 0, 0, 0, 6'b000111, 0, 0);
        add(0, 0, 0, 0, 6'b000000, 0, 0);
        add(0, 0, 1, 1, 6'b000000, 0, 0);
        add(0, 0, 0, 0, 6'b000000, 0, 0);
        add(1, 1, 0, 0, 6'b001111, 0, 0);
        add(0, 1, 0, 0, 6'b001111, 0, 0);
        add(0, 0, 0, 1, 6'b000000, 0, 0);
        add(0, 0, 0, 0, 6'b000000, 0, 0);
        // Five-cycle multi-cycle op.
        add(0, 0, 1, 0, 6'b001111, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 6'b001111, 1, 0);
        add(0, 0, 0, 1, 6'b000000, 1, 0);
        add(0, 0, 0, 0, 6'b000000, 0, 0);
        // ID request held under an EX stall surfaces when done arrives.
        add(0, 0, 1, 0, 6'b001111, 0, 0);
        add(1, 0, 0, 0, 6'b001111, 1, 0);
        add(1, 0, 0, 0, 6'b001111, 1, 0);
        add(1, 0, 0, 1, 6'b000111, 1, 0);
        add(0, 0, 0, 0, 6'b000000, 0, 0);
        // Start while busy is ignored.
        add(0, 0, 1, 0, 6'b001111, 0, 0);
        add(0, 0, 1, 0, 6'b001111, 1, 0);
        add(0, 0, 1, 0, 6'b001111, 1, 0);
        add(0, 0, 0, 1, 6'b000000, 1, 0);
        add(0, 0, 0, 0, 6'b000000, 0, 0);
        // Done in the same cycle the timer reaches its limit wins over the watchdog.
        add(0, 0, 1, 0, 6'b001111, 0, 0);
        for (int i = 0; i < MC_TIMEOUT - 1; i++) add(0, 0, 0, 0, 6'b001111, 1, 0);
        add(0, 0, 0, 1, 6'b000000, 1, 0);
        add(0, 0, 0, 0, 6'b000000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].id, vecs[i].ex, vecs[i].start, vecs[i].done,
                 vecs[i].exp_stall, vecs[i].exp_busy, vecs[i].exp_tmo);
        end

        // Watchdog: no done, stall held MC_TIMEOUT cycles, sticky flag afterwards.
        step("to_start", 0, 0, 1, 0, 6'b001111, 0, 0);
        for (int i = 0; i < MC_TIMEOUT - 1; i++) step("to_hold", 0, 0, 0, 0, 6'b001111, 1, 0);
        step("to_hit", 0, 0, 0, 0, 6'b000000, 1, 0);
        step("to_idle", 0, 0, 0, 0, 6'b000000, 0, 1);
        step("to_op2", 0, 0, 1, 0, 6'b001111, 0, 1);
        step("to_op2b", 0, 0, 0, 0, 6'b001111, 1, 1);
        step("to_op2d", 0, 0, 0, 1, 6'b000000, 1, 1);
        step("to_after", 0, 0, 0, 0, 6'b000000, 0, 1);

        // Asynchronous reset in the middle of an op.
        step("ar_start", 0, 0, 1, 0, 6'b001111, 0, 1);
        step("ar_busy", 0, 0, 0, 0, 6'b001111, 1, 1);
        @(negedge clk);
        #2;
        bus.stallreq_id = 1'b1;
        bus.stallreq_ex = 1'b1;
        rst = 1'b1;
        #1;
        check("ar.stall", 32'(bus.stall), 32'h0);
        check("ar.busy", 32'(bus.mc_busy), 32'h0);
        check("ar.tmo", 32'(bus.mc_timeout), 32'h0);
        check("ar.cnt", 32'(bus.stall_cnt), 32'h0);
        @(negedge clk);
        check("ar_hold.stall", 32'(bus.stall), 32'h0);
        bus.stallreq_id = 1'b0;
        bus.stallreq_ex = 1'b0;
        rst = 1'b0;
        exp_cnt = '0;
        step("ar_stray", 0, 0, 0, 1, 6'b000000, 0, 0);
        step("ar_idle", 0, 0, 0, 0, 6'b000000, 0, 0);
        step("ar_id", 1, 0, 0, 0, 6'b000111, 0, 0);
        step("ar_end", 0, 0, 0, 0, 6'b000000, 0, 0);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
